// File: rtl/axi_tdd_counter.sv
// -----------------------------------------------------------------------------
// axi_tdd_counter -- TDD frame timing counter.
//
// Waits for a sync event (external edge, software pulse or optional internal
// generator), optionally delays, then runs frames of (frame_length+1) cycles.
// A burst of N frames returns to ARMED; N=0 runs forever.
//
// Optional feature macro: AXI_TDD_SYNC_GEN_EN (internal periodic sync source).
//
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   tdd_enable             : level enable; low forces IDLE on the next cycle
//   tdd_sync               : external sync (already in clk domain), rising edge
//   tdd_sync_soft          : one-cycle software sync pulse
//   asy_tdd_*              : configuration, sampled only while IDLE
//   tdd_counter            : frame counter (registered)
//   tdd_cstate             : current FSM state (registered)
//   tdd_endof_frame        : high in the last cycle of each frame (registered)
//   tdd_sync_out           : one-cycle pulse per accepted sync event (registered)
// -----------------------------------------------------------------------------
package axi_tdd_pkg;
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_WAITING = 2'd2;
    localparam logic [1:0] ST_RUNNING = 2'd3;
endpackage

module axi_tdd_counter
    import axi_tdd_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH    = 32,
    parameter int unsigned BURST_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tdd_enable,
    input  logic                          tdd_sync,
    input  logic                          tdd_sync_soft,
    input  logic                          asy_tdd_sync_rst,
    input  logic [REGISTER_WIDTH-1:0]     asy_tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]     asy_tdd_frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0]  asy_tdd_burst_count,
    input  logic [REGISTER_WIDTH-1:0]     asy_tdd_sync_period,
    output logic [REGISTER_WIDTH-1:0]     tdd_counter,
    output axi_tdd_pkg::state_t           tdd_cstate,
    output logic                          tdd_endof_frame,
    output logic                          tdd_sync_out
);

    localparam int unsigned RW = REGISTER_WIDTH;
    localparam int unsigned BW = BURST_COUNT_WIDTH;

    // Configuration shadow registers (track inputs while IDLE, frozen otherwise)
    logic          sync_rst_q;
    logic [RW-1:0] startup_delay_q;
    logic [RW-1:0] frame_length_q;
    logic [BW-1:0] burst_count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_rst_q      <= 1'b0;
            startup_delay_q <= '0;
            frame_length_q  <= '0;
            burst_count_q   <= '0;
        end else if (tdd_cstate == ST_IDLE) begin
            sync_rst_q      <= asy_tdd_sync_rst;
            startup_delay_q <= asy_tdd_startup_delay;
            frame_length_q  <= asy_tdd_frame_length;
            burst_count_q   <= asy_tdd_burst_count;
        end
    end

    // External sync edge detector
    logic tdd_sync_d;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tdd_sync_d <= 1'b0;
        else         tdd_sync_d <= tdd_sync;
    end

    logic sync_gen_pulse_c;

`ifdef AXI_TDD_SYNC_GEN_EN
    // Free-running internal sync generator, active outside IDLE
    logic [RW-1:0] sync_period_q;
    logic [RW-1:0] sync_gen_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     sync_period_q <= '0;
        else if (tdd_cstate == ST_IDLE)  sync_period_q <= asy_tdd_sync_period;
    end

    assign sync_gen_pulse_c = (tdd_cstate != ST_IDLE) && (sync_period_q != '0) &&
                              (sync_gen_cnt == sync_period_q - RW'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                              sync_gen_cnt <= '0;
        else if ((tdd_cstate == ST_IDLE) || (sync_period_q == '0)) sync_gen_cnt <= '0;
        else if (sync_gen_pulse_c)                                sync_gen_cnt <= '0;
        else                                                      sync_gen_cnt <= sync_gen_cnt + RW'(1);
    end
`else
    logic unused_sync_period;
    assign unused_sync_period = ^asy_tdd_sync_period;
    assign sync_gen_pulse_c   = 1'b0;
`endif

    logic sync_event_c;
    assign sync_event_c = (tdd_sync & ~tdd_sync_d) | tdd_sync_soft | sync_gen_pulse_c;

    // FSM state and counters
    state_t        state_nxt;
    logic [RW-1:0] counter_nxt;
    logic [RW-1:0] delay_cnt, delay_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          sync_out_nxt;
    logic          eof_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdd_cstate      <= ST_IDLE;
            tdd_counter     <= '0;
            delay_cnt       <= '0;
            burst_cnt       <= '0;
            tdd_sync_out    <= 1'b0;
            tdd_endof_frame <= 1'b0;
        end else begin
            tdd_cstate      <= state_nxt;
            tdd_counter     <= counter_nxt;
            delay_cnt       <= delay_nxt;
            burst_cnt       <= burst_nxt;
            tdd_sync_out    <= sync_out_nxt;
            tdd_endof_frame <= eof_nxt;
        end
    end

    // Next-state / next-counter logic; disable overrides everything
    always_comb begin
        state_nxt    = tdd_cstate;
        counter_nxt  = tdd_counter;
        delay_nxt    = delay_cnt;
        burst_nxt    = burst_cnt;
        sync_out_nxt = 1'b0;

        if (!tdd_enable) begin
            state_nxt   = ST_IDLE;
            counter_nxt = '0;
            delay_nxt   = '0;
            burst_nxt   = '0;
        end else begin
            case (tdd_cstate)
                ST_IDLE: begin
                    state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (sync_event_c) begin
                        sync_out_nxt = 1'b1;
                        counter_nxt  = '0;
                        delay_nxt    = '0;
                        if (startup_delay_q != '0) begin
                            state_nxt = ST_WAITING;
                        end else begin
                            state_nxt = ST_RUNNING;
                            burst_nxt = burst_count_q;
                        end
                    end
                end
                ST_WAITING: begin
                    if (delay_cnt == startup_delay_q - RW'(1)) begin
                        state_nxt   = ST_RUNNING;
                        counter_nxt = '0;
                        delay_nxt   = '0;
                        burst_nxt   = burst_count_q;
                    end else begin
                        delay_nxt = delay_cnt + RW'(1);
                    end
                end
                ST_RUNNING: begin
                    // A resync wins over the end-of-burst return to ARMED
                    if (sync_event_c && sync_rst_q) begin
                        counter_nxt  = '0;
                        burst_nxt    = burst_count_q;
                        sync_out_nxt = 1'b1;
                    end else if (tdd_endof_frame) begin
                        counter_nxt = '0;
                        if (burst_count_q != '0) begin
                            if (burst_cnt == BW'(1)) begin
                                state_nxt = ST_ARMED;
                                burst_nxt = '0;
                            end else begin
                                burst_nxt = burst_cnt - BW'(1);
                            end
                        end
                    end else begin
                        counter_nxt = tdd_counter + RW'(1);
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    counter_nxt = '0;
                    delay_nxt   = '0;
                    burst_nxt   = '0;
                end
            endcase
        end

        // Frame config is frozen whenever the next state is RUNNING
        eof_nxt = (state_nxt == ST_RUNNING) && (counter_nxt == frame_length_q);
    end

endmodule

// File: doc/axi_tdd_counter.md
AXI_TDD_COUNTER -- requirements
Module: axi_tdd_counter

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 32, width of counter, delay and length registers.
REQ-002 SHALL have parameter BURST_COUNT_WIDTH, default 32, width of burst counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic in this domain.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port tdd_enable  input  1  module enable; level.
REQ-006 SHALL have port tdd_sync  input  1  external sync, pre-synchronised to clk; rising edge is the event.
REQ-007 SHALL have port tdd_sync_soft  input  1  software sync; one-cycle pulse.
REQ-008 SHALL have port asy_tdd_sync_rst  input  1  1 = sync events restart the frame while RUNNING.
REQ-009 SHALL have port asy_tdd_startup_delay  input  REGISTER_WIDTH  cycles between sync event and first frame.
REQ-010 SHALL have port asy_tdd_frame_length  input  REGISTER_WIDTH  last counter value of a frame (frame = value+1 cycles).
REQ-011 SHALL have port asy_tdd_burst_count  input  BURST_COUNT_WIDTH  frames per burst; 0 = infinite.
REQ-012 SHALL have port asy_tdd_sync_period  input  REGISTER_WIDTH  internal sync period; only with AXI_TDD_SYNC_GEN_EN.
REQ-013 SHALL have port tdd_counter  output  REGISTER_WIDTH  frame counter.
REQ-014 SHALL have port tdd_cstate  output  axi_tdd_pkg::state_t  current state.
REQ-015 SHALL have port tdd_endof_frame  output  1  high in the last cycle of each frame.
REQ-016 SHALL have port tdd_sync_out  output  1  registered one-cycle pulse per accepted sync event.

Function
REQ-017 SHALL capture all asy_* inputs into internal registers on every cycle where tdd_cstate==IDLE, and hold them in all other states.
REQ-018 SHALL form sync_event = (rising edge of tdd_sync) OR tdd_sync_soft OR internal sync pulse (when compiled in).
REQ-019 SHALL implement states IDLE, ARMED, WAITING, RUNNING; tdd_cstate is registered.
REQ-020 SHALL go IDLE->ARMED on the cycle after tdd_enable is sampled high.
REQ-021 SHALL go ARMED->WAITING on sync_event if startup_delay!=0, else ARMED->RUNNING with tdd_counter=0 on the next cycle.
REQ-022 SHALL in WAITING count a delay counter from 0; on delay==startup_delay-1 go to RUNNING with tdd_counter=0 on the next cycle.
REQ-023 SHALL in RUNNING increment tdd_counter by 1 per cycle and wrap it to 0 after value frame_length.
REQ-024 SHALL assert tdd_endof_frame exactly in cycles where tdd_cstate==RUNNING and tdd_counter==frame_length; frame_length=0 gives endof_frame every cycle.
REQ-025 SHALL load the burst counter with burst_count on entry to RUNNING and decrement it at each endof_frame when burst_count!=0.
REQ-026 SHALL go RUNNING->ARMED after endof_frame when the burst counter value is 1; with burst_count==0, RUNNING persists.
REQ-027 SHALL, when sync_rst=1 and sync_event occurs in RUNNING, restart the frame: tdd_counter=0 and burst counter reloaded on the next cycle; with sync_rst=0, sync_event in RUNNING/WAITING is ignored.
REQ-028 SHALL, when sync_event coincides with endof_frame of the last burst frame and sync_rst=1, restart the frame rather than go to ARMED.
REQ-029 SHALL go to IDLE from any state on the cycle after tdd_enable is sampled low, clearing tdd_counter, delay and burst counters; this takes priority over all other transitions.
REQ-030 SHALL pulse tdd_sync_out one cycle after each sync_event accepted in ARMED or in RUNNING with sync_rst=1.
REQ-031 SHALL hold tdd_counter at 0 in IDLE, ARMED and WAITING.

Reset
REQ-032 SHALL on resetn low asynchronously force tdd_cstate=IDLE, tdd_counter=0, tdd_endof_frame=0, tdd_sync_out=0, all internal counters and captured registers to 0.
REQ-033 SHALL, after resetn deassertion mid-operation, restart from IDLE and require a new sync_event before RUNNING.

Configuration
REQ-034 SHALL with macro AXI_TDD_SYNC_GEN_EN defined include a free-running sync generator: counter counts 0..sync_period-1 whenever tdd_cstate!=IDLE, pulsing internally at wrap; sync_period=0 disables it.
REQ-035 SHALL without AXI_TDD_SYNC_GEN_EN omit the generator, ignore asy_tdd_sync_period, and use only tdd_sync and tdd_sync_soft.

Verification
REQ-036 SHALL verify: enable, delay=3, frame_length=9, burst=2, one tdd_sync edge -> WAITING 3 cycles, RUNNING counter 0..9 twice, endof_frame at counter 9 twice, then ARMED.
REQ-037 SHALL verify: delay=0, burst=0, sync_soft pulse -> RUNNING next cycle, infinite frames, no return to ARMED for 100 frames.
REQ-038 SHALL verify: sync_rst=1, RUNNING frame_length=99, sync at counter 40 -> counter 0 next cycle, tdd_sync_out pulse; with sync_rst=0 -> counter 41, no pulse.
REQ-039 SHALL verify: tdd_enable low at counter 5 in RUNNING -> IDLE and counter 0 next cycle; frame_length change while RUNNING has no effect until IDLE.
REQ-040 SHALL verify: resetn asserted in WAITING -> outputs 0/IDLE immediately without a clock edge; frame_length=0 -> endof_frame high every RUNNING cycle.
REQ-041 SHALL verify with AXI_TDD_SYNC_GEN_EN: sync_period=50, no external sync -> RUNNING entered 50 cycles after ARMED, tdd_sync_out every 50 cycles.
